// File: rtl/game_pkg.sv
// Shared definitions for the shooter game flow controller: state encodings
// (also decoded by the LED indicators) and BCD score helpers.
package game_pkg;

    localparam int BCD_DIGIT_W = 4;

    localparam logic [1:0] QI     = 2'b00;
    localparam logic [1:0] QGAME  = 2'b01;
    localparam logic [1:0] QCLEAR = 2'b10;
    localparam logic [1:0] QDONE  = 2'b11;

    function automatic logic [6:0] bcd_to_bin(input logic [2*BCD_DIGIT_W-1:0] bcd);
        return 7'(bcd[7:4] * 4'd10) + 7'(bcd[3:0]);
    endfunction

endpackage

// File: rtl/bcd_sat_adder.sv
// Two-digit BCD plus a 0..15 binary addend, saturating at 99.
module bcd_sat_adder
    import game_pkg::*;
(
    input  logic [2*BCD_DIGIT_W-1:0] bcd_in,
    input  logic [3:0]               addend,
    output logic [2*BCD_DIGIT_W-1:0] bcd_out
);

    logic [7:0] sum_bin;

    // Sum in binary (max 99+15), then split back into digits.
    always_comb begin
        sum_bin = {1'b0, bcd_to_bin(bcd_in)} + {4'b0, addend};
        if (sum_bin >= 8'd99) begin
            bcd_out = 8'h99;
        end else begin
            bcd_out[7:4] = 4'(sum_bin / 8'd10);
            bcd_out[3:0] = 4'(sum_bin % 8'd10);
        end
    end

endmodule

// File: rtl/game_flow_controller.sv
// Game sequencer: state, level, shot budget, BCD score, fire grants and engine clears.
// Define BONUS_SCORE_EN to award unused shots as score when a level is cleared.
module game_flow_controller
    import game_pkg::*;
#(
    parameter int NUM_TARGETS      = 2,
    parameter int SHOTS_PER_LEVEL  = 6,
    parameter int MAX_LEVEL        = 9,
    parameter int CLEAR_HOLD_TICKS = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   tick,
    input  logic                   start,
    input  logic                   fire_req,
    input  logic                   bullet_active,
    input  logic [NUM_TARGETS-1:0] hit_pulse,
    output logic                   fire_grant,
    output logic                   engine_clear,
    output logic                   engine_run,
    output logic [1:0]             state,
    output logic [3:0]             level,
    output logic [3:0]             shots_left,
    output logic [7:0]             score,
    output logic                   game_won
);

    localparam logic [3:0] SHOTS_INIT = 4'(SHOTS_PER_LEVEL);
    localparam logic [3:0] LEVEL_LAST = 4'(MAX_LEVEL);
    localparam logic [7:0] HOLD_LAST  = 8'(CLEAR_HOLD_TICKS - 1);

    logic [1:0]             state_reg, state_next;
    logic [3:0]             level_reg, level_next;
    logic [3:0]             shots_reg, shots_next;
    logic [7:0]             score_reg, score_next;
    logic [NUM_TARGETS-1:0] mask_reg, mask_next;
    logic [7:0]             hold_reg, hold_next;
    logic                   fire_grant_reg, fire_grant_next;
    logic                   engine_clear_reg, engine_clear_next;
    logic                   won_reg, won_next;

    logic [NUM_TARGETS-1:0] new_hits;
    logic [3:0]             hit_count;
    logic                   mask_full;
    logic                   grant_ok;
    logic [3:0]             adder_addend;
    logic [7:0]             adder_sum;

    for (genvar gi = 0; gi < NUM_TARGETS; gi++) begin : g_new_hits
        assign new_hits[gi] = hit_pulse[gi] & ~mask_reg[gi];
    end

    always_comb begin
        hit_count = '0;
        for (int i = 0; i < NUM_TARGETS; i++) begin
            hit_count = hit_count + 4'(new_hits[i]);
        end
    end

    // A completing hit suppresses the shot on the same tick.
    assign mask_full = &(mask_reg | hit_pulse);
    assign grant_ok  = fire_req && !bullet_active && (shots_reg != 4'd0) && !mask_full;

    always_comb begin
`ifdef BONUS_SCORE_EN
        adder_addend = (state_reg == QCLEAR) ? shots_reg : hit_count;
`else
        adder_addend = hit_count;
`endif
    end

    bcd_sat_adder u_score_adder (
        .bcd_in  (score_reg),
        .addend  (adder_addend),
        .bcd_out (adder_sum)
    );

    always_comb begin
        state_next        = state_reg;
        level_next        = level_reg;
        shots_next        = shots_reg;
        score_next        = score_reg;
        mask_next         = mask_reg;
        hold_next         = hold_reg;
        won_next          = won_reg;
        fire_grant_next   = 1'b0;
        engine_clear_next = 1'b0;

        case (state_reg)
            QI: begin
                if (tick && start) begin
                    state_next        = QGAME;
                    level_next        = 4'd1;
                    score_next        = 8'h00;
                    shots_next        = SHOTS_INIT;
                    mask_next         = '0;
                    won_next          = 1'b0;
                    engine_clear_next = 1'b1;
                end
            end
            QGAME: begin
                if (tick) begin
                    mask_next  = mask_reg | hit_pulse;
                    score_next = adder_sum;
                    if (grant_ok) begin
                        fire_grant_next = 1'b1;
                        shots_next      = shots_reg - 4'd1;
                    end
                    if (mask_full) begin
                        state_next = QCLEAR;
                        hold_next  = 8'd0;
                    end else if (shots_reg == 4'd0 && !bullet_active) begin
                        state_next = QDONE;
                        won_next   = 1'b0;
                    end
                end
            end
            QCLEAR: begin
                if (tick) begin
                    hold_next = hold_reg + 8'd1;
                    if (hold_reg == HOLD_LAST) begin
`ifdef BONUS_SCORE_EN
                        score_next = adder_sum;
`endif
                        if (level_reg == LEVEL_LAST) begin
                            state_next = QDONE;
                            won_next   = 1'b1;
                        end else begin
                            state_next        = QGAME;
                            level_next        = level_reg + 4'd1;
                            shots_next        = SHOTS_INIT;
                            mask_next         = '0;
                            engine_clear_next = 1'b1;
                        end
                    end
                end
            end
            QDONE: begin
                if (tick && !start) begin
                    state_next = QI;
                    won_next   = 1'b0;
                end
            end
            default: state_next = QI;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg        <= QI;
            level_reg        <= 4'd0;
            shots_reg        <= 4'd0;
            score_reg        <= 8'h00;
            mask_reg         <= '0;
            hold_reg         <= 8'd0;
            won_reg          <= 1'b0;
            fire_grant_reg   <= 1'b0;
            engine_clear_reg <= 1'b0;
        end else begin
            state_reg        <= state_next;
            level_reg        <= level_next;
            shots_reg        <= shots_next;
            score_reg        <= score_next;
            mask_reg         <= mask_next;
            hold_reg         <= hold_next;
            won_reg          <= won_next;
            fire_grant_reg   <= fire_grant_next;
            engine_clear_reg <= engine_clear_next;
        end
    end

    assign state        = state_reg;
    assign level        = level_reg;
    assign shots_left   = shots_reg;
    assign score        = score_reg;
    assign game_won     = won_reg;
    assign fire_grant   = fire_grant_reg;
    assign engine_clear = engine_clear_reg;
    assign engine_run   = (state_reg == QGAME);

endmodule

// File: tb/tb_game_flow_controller.sv
// Directed bench for game_flow_controller (default parameters) plus a
// vector table for the saturating BCD adder.
module tb_game_flow_controller;
    import game_pkg::*;

`ifdef BONUS_SCORE_EN
    localparam bit BONUS = 1'b1;
`else
    localparam bit BONUS = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       tick;
    logic       start;
    logic       fire_req;
    logic       bullet_active;
    logic [1:0] hit_pulse;
    logic       fire_grant;
    logic       engine_clear;
    logic       engine_run;
    logic [1:0] state;
    logic [3:0] level;
    logic [3:0] shots_left;
    logic [7:0] score;
    logic       game_won;

    logic [7:0] add_in;
    logic [3:0] add_k;
    logic [7:0] add_out;

    always #5 clk = ~clk;

    game_flow_controller dut (
        .clk           (clk),
        .reset         (reset),
        .tick          (tick),
        .start         (start),
        .fire_req      (fire_req),
        .bullet_active (bullet_active),
        .hit_pulse     (hit_pulse),
        .fire_grant    (fire_grant),
        .engine_clear  (engine_clear),
        .engine_run    (engine_run),
        .state         (state),
        .level         (level),
        .shots_left    (shots_left),
        .score         (score),
        .game_won      (game_won)
    );

    bcd_sat_adder u_add (
        .bcd_in  (add_in),
        .addend  (add_k),
        .bcd_out (add_out)
    );

    typedef struct {
        logic [7:0] bcd;
        logic [3:0] k;
        logic [7:0] expect_sum;
    } add_vec_t;

    add_vec_t vecs[8];
    int n_checks = 0;
    int n_fail   = 0;
    int tick_no  = 0;
    int exp_score;
    int grants;
    int bonus_shots;

    function automatic int to_bcd(input int v);
        int s;
        s = (v > 99) ? 99 : v;
        return (s / 10) * 16 + (s % 10);
    endfunction

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (tick %0d)", name, act, req, tick_no);
        end
    endtask

    // One game tick: inputs set on a falling edge, outputs visible at the next one.
    task automatic do_tick(input logic s, input logic f, input logic b, input logic [1:0] h);
        @(negedge clk);
        start = s; fire_req = f; bullet_active = b; hit_pulse = h; tick = 1'b1;
        @(negedge clk);
        tick = 1'b0; hit_pulse = 2'b00;
        tick_no++;
        $display("tick %0d: start=%b fire=%b bullet=%b hit=%b -> state=%b level=%0d shots=%0d score=%h grant=%b clear=%b won=%b",
                 tick_no, s, f, b, h, state, level, shots_left, score, fire_grant, engine_clear, game_won);
    endtask

    task automatic run_ticks(input int n);
        for (int i = 0; i < n; i++) do_tick(1'b1, 1'b0, 1'b0, 2'b00);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " state"}, int'(state), int'(QI));
        check({tag, " level"}, int'(level), 0);
        check({tag, " shots"}, int'(shots_left), 0);
        check({tag, " score"}, int'(score), 0);
        check({tag, " engine_run"}, int'(engine_run), 0);
        check({tag, " fire_grant"}, int'(fire_grant), 0);
        check({tag, " engine_clear"}, int'(engine_clear), 0);
        check({tag, " game_won"}, int'(game_won), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{8'h00, 4'd0,  8'h00};
        vecs[1] = '{8'h00, 4'd1,  8'h01};
        vecs[2] = '{8'h09, 4'd1,  8'h10};
        vecs[3] = '{8'h19, 4'd4,  8'h23};
        vecs[4] = '{8'h98, 4'd2,  8'h99};
        vecs[5] = '{8'h99, 4'd1,  8'h99};
        vecs[6] = '{8'h80, 4'd15, 8'h95};
        vecs[7] = '{8'h95, 4'd15, 8'h99};

        reset = 1'b1; tick = 1'b0; start = 1'b0; fire_req = 1'b0;
        bullet_active = 1'b0; hit_pulse = 2'b00; add_in = 8'h00; add_k = 4'd0;

        for (int i = 0; i < 8; i++) begin
            add_in = vecs[i].bcd;
            add_k  = vecs[i].k;
            #1;
            $display("adder vec %0d: %h + %0d -> %h", i, add_in, add_k, add_out);
            check("bcd_adder", int'(add_out), int'(vecs[i].expect_sum));
        end

        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        reset = 1'b0;

        // Start of game.
        do_tick(1'b1, 1'b0, 1'b0, 2'b00);
        exp_score = 0;
        check("start state", int'(state), int'(QGAME));
        check("start level", int'(level), 1);
        check("start shots", int'(shots_left), 6);
        check("start score", int'(score), 0);
        check("start engine_clear", int'(engine_clear), 1);
        check("start engine_run", int'(engine_run), 1);
        @(negedge clk);
        check("engine_clear one clk", int'(engine_clear), 0);

        // Repeated hit on the same target scores once.
        do_tick(1'b1, 1'b0, 1'b0, 2'b01);
        check("hit1 score", int'(score), 'h01);
        do_tick(1'b1, 1'b0, 1'b0, 2'b01);
        check("hit repeat score", int'(score), 'h01);
        check("hit repeat state", int'(state), int'(QGAME));
        do_tick(1'b1, 1'b0, 1'b0, 2'b10);
        exp_score = 2;
        check("hit2 score", int'(score), 'h02);
        check("clear state", int'(state), int'(QCLEAR));
        check("clear engine_run", int'(engine_run), 0);

        run_ticks(63);
        check("hold 63 state", int'(state), int'(QCLEAR));
        run_ticks(1);
        if (BONUS) exp_score += 6;
        check("lvl2 state", int'(state), int'(QGAME));
        check("lvl2 level", int'(level), 2);
        check("lvl2 shots", int'(shots_left), 6);
        check("lvl2 engine_clear", int'(engine_clear), 1);
        check("lvl2 score", int'(score), to_bcd(exp_score));

        // Burn the shot budget with one target hit, then lose.
        do_tick(1'b1, 1'b0, 1'b0, 2'b01);
        exp_score += 1;
        grants = 0;
        for (int i = 1; i <= 10; i++) begin
            do_tick(1'b1, 1'b1, 1'b0, 2'b00);
            if (fire_grant) grants++;
            if (i <= 6) begin
                check("fire grant", int'(fire_grant), 1);
                check("fire shots", int'(shots_left), 6 - i);
            end
            if (i == 7) check("loss state", int'(state), int'(QDONE));
        end
        check("fire grant count", grants, 6);
        check("loss state held", int'(state), int'(QDONE));
        check("loss game_won", int'(game_won), 0);
        check("loss level", int'(level), 2);
        check("loss score", int'(score), to_bcd(exp_score));
        do_tick(1'b0, 1'b0, 1'b0, 2'b00);
        check("done->idle", int'(state), int'(QI));

        // New game: blocked fire, then last shot's hit completes the mask.
        do_tick(1'b1, 1'b0, 1'b0, 2'b00);
        exp_score = 0;
        check("restart level", int'(level), 1);
        check("restart score", int'(score), 0);
        do_tick(1'b1, 1'b1, 1'b1, 2'b00);
        check("busy no grant", int'(fire_grant), 0);
        check("busy shots", int'(shots_left), 6);
        for (int i = 0; i < 5; i++) do_tick(1'b1, 1'b1, 1'b0, 2'b00);
        check("five shots", int'(shots_left), 1);
        do_tick(1'b1, 1'b1, 1'b0, 2'b01);
        exp_score = 1;
        check("last shot grant", int'(fire_grant), 1);
        check("last shot shots", int'(shots_left), 0);
        check("last shot state", int'(state), int'(QGAME));
        do_tick(1'b1, 1'b0, 1'b0, 2'b10);
        exp_score = 2;
        check("late clear state", int'(state), int'(QCLEAR));
        bonus_shots = 0;

        // Advance through levels 2..9; completing tick must not grant.
        for (int lvl = 2; lvl <= 9; lvl++) begin
            run_ticks(64);
            if (BONUS) exp_score += bonus_shots;
            check("advance state", int'(state), int'(QGAME));
            check("advance level", int'(level), lvl);
            check("advance shots", int'(shots_left), 6);
            check("advance score", int'(score), to_bcd(exp_score));
            bonus_shots = 6;
            if (lvl == 9) begin
                for (int i = 0; i < 3; i++) do_tick(1'b1, 1'b1, 1'b0, 2'b00);
                bonus_shots = 3;
            end
            do_tick(1'b1, 1'b1, 1'b0, 2'b11);
            exp_score += 2;
            check("complete no grant", int'(fire_grant), 0);
            check("complete state", int'(state), int'(QCLEAR));
            check("complete shots", int'(shots_left), bonus_shots);
        end
        run_ticks(63);
        check("final hold state", int'(state), int'(QCLEAR));
        run_ticks(1);
        if (BONUS) exp_score += bonus_shots;
        check("win state", int'(state), int'(QDONE));
        check("win game_won", int'(game_won), 1);
        check("win level", int'(level), 9);
        check("win score", int'(score), to_bcd(exp_score));
        check("win engine_run", int'(engine_run), 0);
        check("win engine_clear", int'(engine_clear), 0);
        do_tick(1'b0, 1'b0, 1'b0, 2'b00);
        check("win->idle", int'(state), int'(QI));

        // Reset in the middle of QCLEAR, with tick high.
        do_tick(1'b1, 1'b0, 1'b0, 2'b00);
        do_tick(1'b1, 1'b0, 1'b0, 2'b11);
        check("pre-reset state", int'(state), int'(QCLEAR));
        run_ticks(5);
        @(negedge clk);
        reset = 1'b1; tick = 1'b1;
        @(negedge clk);
        reset = 1'b0; tick = 1'b0;
        check_reset_outputs("midclear reset");

        // Reset on the cycle carrying fire_grant.
        do_tick(1'b1, 1'b0, 1'b0, 2'b00);
        do_tick(1'b1, 1'b1, 1'b0, 2'b00);
        check("pre-reset grant", int'(fire_grant), 1);
        reset = 1'b1; tick = 1'b1; fire_req = 1'b1;
        @(negedge clk);
        reset = 1'b0; tick = 1'b0; fire_req = 1'b0;
        check_reset_outputs("grant reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
